// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral feeding a bank of NUM_REGS addressed registers.
// All SPI pins are oversampled in the clk domain. A frame is 1 R/W bit, ADDR_W address
// bits and DATA_W data bits, sent MSB first. When ncs rises, the frame is committed as a
// register write, a silent read, or a frame_err pulse.
// Optional feature: define SPI_READBACK_EN to drive the addressed register out on cipo
// during read frames. Without it, cipo is tied low.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  // Synchroniser chains; index SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_rise;
  logic ncs_fall;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [FRAME_W-1:0]     shift_reg;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic                   frame_rw;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;
  logic                   addr_ok;

  // Bring the asynchronous SPI pins into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample the old value,
      // so each stage really adds one cycle of delay.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // Decode the captured frame for the commit decision.
  assign frame_rw   = shift_reg[FRAME_W-1];
  assign frame_addr = shift_reg[FRAME_W-2 -: ADDR_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign addr_ok    = {1'b0, frame_addr} < NUM_REGS_A;

  // Frame FSM: shift bits while selected, then validate and commit on deselect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      // NOTE: the bank is small and drives PWM blocks directly, so it is reset like any
      // other register; a large memory would normally be left unreset.
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state     <= SHIFT;
            cnt       <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], copi_s};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
          if (ncs_rise) state <= COMMIT;
        end
        COMMIT: begin
          if (cnt != CNT_FULL || !addr_ok) begin
            frame_err <= 1'b1;
          end else if (frame_rw) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (frame_addr == ADDR_W'(k)) regs[k] <= frame_data;
            end
            wr_stb  <= 1'b1;
            wr_addr <= frame_addr;
          end
          // A new selection arriving while committing starts the next frame directly.
          if (ncs_fall) begin
            state     <= SHIFT;
            cnt       <= '0;
            shift_reg <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_pack
      assign regs_o[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx;
  logic [ADDR_W:0]   hdr;
  logic [DATA_W-1:0] rd_data;
  logic              sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d;
  // Header as it stands once the current rise has shifted the last address bit in.
  assign hdr = {shift_reg[ADDR_W-1:0], copi_s};

  // Select the register addressed by the header for loading into the tx shifter.
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hdr[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs[k];
    end
  end

  // Read-back shifter: load after the header, then shift on each following sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= '0;
    end else if (state != SHIFT) begin
      tx <= '0;
    end else if (sclk_rise && cnt == CNT_W'(ADDR_W)) begin
      tx <= (!hdr[ADDR_W] && ({1'b0, hdr[ADDR_W-1:0]} < NUM_REGS_A)) ? rd_data : '0;
    end else if (sclk_fall && cnt >= CNT_W'(ADDR_W + 2)) begin
      // The fall right after the load is skipped so the controller samples the MSB first.
      tx <= {tx[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo = tx[DATA_W-1] & ~ncs_s;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed and randomized SPI frames against a register-bank model.
// Define SPI_READBACK_EN to also check read-back data on cipo.
module tb_spi_reg_bank;

  localparam int NUM_REGS    = 5;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic                       clk  = 1'b0;
  logic                       rst  = 1'b1;
  logic                       sclk = 1'b0;
  logic                       copi = 1'b0;
  logic                       ncs  = 1'b1;
  logic                       cipo;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic                       wr_stb;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  spi_reg_bank #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .regs_o(regs_o), .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [ADDR_W-1:0] m_wr_addr;

  // Pulse monitors
  int stb_cycles = 0;
  int err_cycles = 0;
  int cycle_cnt  = 0;
  int rise_cyc   = 0;
  int last_lat   = -1;

  always @(posedge clk) cycle_cnt++;
  always @(posedge ncs) rise_cyc = cycle_cnt;
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cycles++;
      last_lat = cycle_cnt - rise_cyc;
    end
    if (frame_err === 1'b1) err_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_bank();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_regs[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_wr_addr = '0;
  endtask

  // Drive one frame MSB first; abort_at >= 0 pulses rst while that bit is on the wire.
  task automatic send_frame(input logic [31:0] f, input int len, input int gap,
                            input int abort_at, output logic [DATA_W-1:0] rx);
    rx  = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int p = 0; p < len; p++) begin
      copi = f[len-1-p];
      if (p == abort_at) begin
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (p >= 1 + ADDR_W && p < 1 + ADDR_W + DATA_W) rx = {rx[DATA_W-2:0], cipo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ncs  = 1'b1;
    copi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Send a frame and compare every output against the model.
  task automatic run_frame(input logic [31:0] f, input int len, input string tag);
    logic [DATA_W-1:0] rx;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              exp_err;
    logic              exp_stb;
    logic [DATA_W-1:0] exp_rx;
    int                s0;
    int                e0;
    rw      = f[15];
    addr    = f[14:8];
    data    = f[7:0];
    exp_err = (len != 16) || (addr >= NUM_REGS);
    exp_stb = !exp_err && rw;
    exp_rx  = (len == 16 && !rw && addr < NUM_REGS) ? m_regs[addr] : '0;
    s0 = stb_cycles;
    e0 = err_cycles;
    send_frame(f, len, 20, -1, rx);
    if (exp_stb) begin
      m_regs[addr] = data;
      m_wr_addr    = addr;
    end
    check({tag, " wr_stb"}, 64'(stb_cycles - s0), 64'(exp_stb));
    check({tag, " frame_err"}, 64'(err_cycles - e0), 64'(exp_err));
    check({tag, " regs_o"}, 64'(regs_o), 64'(model_bank()));
    check({tag, " wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    check({tag, " cipo idle"}, 64'(cipo), 64'(0));
    if (exp_stb) check({tag, " latency"}, 64'(last_lat), 64'(SYNC_STAGES + 2));
`ifdef SPI_READBACK_EN
    if (len == 16) check({tag, " readback"}, 64'(rx), 64'(exp_rx));
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] rx;
    logic [31:0]       f;
    int                len;
    int                s0;
    int                e0;

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("reset regs_o", 64'(regs_o), 64'(0));
    check("reset wr_stb", 64'(wr_stb), 64'(0));
    check("reset wr_addr", 64'(wr_addr), 64'(0));
    check("reset frame_err", 64'(frame_err), 64'(0));
    check("reset cipo", 64'(cipo), 64'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Valid write, then out-of-range write
    run_frame(32'h82A5, 16, "t1 write a2");
    run_frame(32'h853C, 16, "t2 addr oob");

    // Short and long frames carrying a valid write header
    run_frame(32'h82A5 >> 1, 15, "t3 short");
    run_frame({15'h0, 16'h82A5, 1'b1}, 17, "t3 long");

    // Reset mid-frame aborts silently, then a full write goes through
    s0 = stb_cycles;
    e0 = err_cycles;
    send_frame(32'h81FF, 16, 0, 9, rx);
    model_reset();
    check("t4 abort wr_stb", 64'(stb_cycles - s0), 64'(0));
    check("t4 abort frame_err", 64'(err_cycles - e0), 64'(0));
    check("t4 abort regs_o", 64'(regs_o), 64'(0));
    run_frame(32'h8111, 16, "t4 after rst");

    // Back-to-back writes, 4 clk apart
    s0 = stb_cycles;
    send_frame(32'h8010, 16, 4, -1, rx);
    send_frame(32'h8420, 16, 20, -1, rx);
    m_regs[0] = 8'h10;
    m_regs[4] = 8'h20;
    m_wr_addr = 7'd4;
    check("t5 wr_stb count", 64'(stb_cycles - s0), 64'(2));
    check("t5 regs_o", 64'(regs_o), 64'(model_bank()));
    check("t5 wr_addr", 64'(wr_addr), 64'(m_wr_addr));

    // Next frame starts while the previous one commits (1 clk deselect)
    s0 = stb_cycles;
    e0 = err_cycles;
    send_frame(32'h8177, 16, 1, -1, rx);
    send_frame(32'h8399, 16, 20, -1, rx);
    m_regs[1] = 8'h77;
    m_regs[3] = 8'h99;
    m_wr_addr = 7'd3;
    check("overlap wr_stb count", 64'(stb_cycles - s0), 64'(2));
    check("overlap frame_err", 64'(err_cycles - e0), 64'(0));
    check("overlap regs_o", 64'(regs_o), 64'(model_bank()));

    // Rewriting the same value still pulses wr_stb
    run_frame(32'h8399, 16, "same value");

    // Read-back of a freshly written register, then reads in and out of range
    run_frame(32'h83C3, 16, "t6 write");
    run_frame(32'h0300, 16, "t6 read");
    run_frame(32'h0400, 16, "read a4");
    run_frame(32'h0600, 16, "read oob");

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      f   = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      len = 16;
      case ($urandom_range(0, 9))
        0:       begin f = f >> 1; len = 15; end
        1:       begin f = {f[30:0], 1'($urandom)}; len = 17; end
        default: ;
      endcase
      run_frame(f, len, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
